// File: rtl/rptr_empty_ae.sv
// Read-side pointer, empty / almost-empty flags, fill count and sticky underflow for an async FIFO.
// Optional macro RPTR_LOOKAHEAD_EN drives raddr from the next binary pointer for registered-read RAMs.
module rptr_empty_ae #(
    parameter int ADDRSIZE = 4
) (
    input  logic                rclk,
    input  logic                rrst,
    input  logic                rinc,
    input  logic [ADDRSIZE:0]   rq2_wptr,
    input  logic [ADDRSIZE:0]   ae_level,
    input  logic                uflow_clr,
    output logic [ADDRSIZE-1:0] raddr,
    output logic [ADDRSIZE:0]   rptr,
    output logic                rempty,
    output logic                raempty,
    output logic [ADDRSIZE:0]   rcount,
    output logic                ruflow
);

    logic [ADDRSIZE:0] rbin_q, rbin_d;
    logic [ADDRSIZE:0] rptr_q, rptr_d;
    logic [ADDRSIZE:0] rcount_q, rcount_d;
    logic              rempty_q, rempty_d;
    logic              raempty_q, raempty_d;
    logic              ruflow_q, ruflow_d;

    logic [ADDRSIZE:0] rbnext;
    logic [ADDRSIZE:0] rgnext;
    logic [ADDRSIZE:0] wbin;
    logic [ADDRSIZE:0] cnt_next;
    logic              pop;
    logic              uflow_set;

    function automatic logic [ADDRSIZE:0] gray2bin(input logic [ADDRSIZE:0] g);
        logic [ADDRSIZE:0] b;
        b[ADDRSIZE] = g[ADDRSIZE];
        for (int i = ADDRSIZE - 1; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    always_comb begin
        pop       = rinc & ~rempty_q;
        uflow_set = rinc & rempty_q;
        rbnext    = rbin_q + {{ADDRSIZE{1'b0}}, pop};
        rgnext    = (rbnext >> 1) ^ rbnext;
        wbin      = gray2bin(rq2_wptr);
        // Modulo subtraction; the synchronised write pointer lags, so this under-reports.
        cnt_next  = wbin - rbnext;

        rbin_d    = rbnext;
        rptr_d    = rgnext;
        rempty_d  = (rgnext == rq2_wptr);
        raempty_d = (cnt_next <= ae_level);
        rcount_d  = cnt_next;
        ruflow_d  = uflow_set | (ruflow_q & ~uflow_clr);
    end

    always_ff @(posedge rclk) begin
        if (rrst) begin
            rbin_q    <= '0;
            rptr_q    <= '0;
            rcount_q  <= '0;
            rempty_q  <= 1'b1;
            raempty_q <= 1'b1;
            ruflow_q  <= 1'b0;
        end else begin
            rbin_q    <= rbin_d;
            rptr_q    <= rptr_d;
            rcount_q  <= rcount_d;
            rempty_q  <= rempty_d;
            raempty_q <= raempty_d;
            ruflow_q  <= ruflow_d;
        end
    end

`ifdef RPTR_LOOKAHEAD_EN
    assign raddr = rbnext[ADDRSIZE-1:0];
`else
    assign raddr = rbin_q[ADDRSIZE-1:0];
`endif

    assign rptr    = rptr_q;
    assign rempty  = rempty_q;
    assign raempty = raempty_q;
    assign rcount  = rcount_q;
    assign ruflow  = ruflow_q;

endmodule

// File: tb/tb_rptr_empty_ae.sv
// Bench for rptr_empty_ae: directed scenarios plus randomized traffic checked against a
// word-count model of the FIFO read side.
module tb_rptr_empty_ae;

    logic       clk = 1'b0;
    logic       rrst = 1'b1;
    logic       rinc = 1'b0;
    logic       uflow_clr = 1'b0;
    logic [4:0] rq2_wptr = 5'd0;
    logic [4:0] ae_level = 5'd1;
    logic [3:0] raddr;
    logic [4:0] rptr;
    logic       rempty;
    logic       raempty;
    logic [4:0] rcount;
    logic       ruflow;

    rptr_empty_ae #(.ADDRSIZE(4)) dut (
        .rclk(clk), .rrst(rrst), .rinc(rinc), .rq2_wptr(rq2_wptr),
        .ae_level(ae_level), .uflow_clr(uflow_clr), .raddr(raddr),
        .rptr(rptr), .rempty(rempty), .raempty(raempty),
        .rcount(rcount), .ruflow(ruflow)
    );

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    // Model state: words popped (mod 32), words available, flags
    int m_rbin = 0;
    int m_cnt  = 0;
    bit m_empty = 1'b1;
    bit m_ae    = 1'b1;
    bit m_uf    = 1'b0;
    bit m_rst   = 1'b1;
    logic [4:0] prev_rptr = 5'd0;
    int wb = 0;

    function automatic int gray(input int b);
        return (b ^ (b >> 1)) & 31;
    endfunction

    function automatic int gdec(input int g);
        for (int b = 0; b < 32; b++) begin
            if (gray(b) == g) return b;
        end
        return 0;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        bit acc;
        bit uset;
        if (rrst) begin
            m_rbin = 0; m_cnt = 0; m_empty = 1'b1; m_ae = 1'b1; m_uf = 1'b0;
        end else begin
            acc    = rinc && !m_empty;
            uset   = rinc && m_empty;
            m_rbin = (m_rbin + int'(acc)) % 32;
            m_cnt  = (gdec(int'(rq2_wptr)) - m_rbin) & 31;
            m_empty = (m_cnt == 0);
            m_ae    = (m_cnt <= int'(ae_level));
            m_uf    = uset ? 1'b1 : (uflow_clr ? 1'b0 : m_uf);
        end
        m_rst = rrst;
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("rptr", rptr, gray(m_rbin));
            chk("rempty", rempty, m_empty);
            chk("raempty", raempty, m_ae);
            chk("rcount", rcount, m_cnt);
            chk("ruflow", ruflow, m_uf);
`ifdef RPTR_LOOKAHEAD_EN
            chk("raddr", raddr, (m_rbin + int'(rinc && !m_empty)) & 15);
`else
            chk("raddr", raddr, m_rbin & 15);
`endif
            if (!m_rst) chk("rptr_onebit", $countones(rptr ^ prev_rptr) <= 1, 1);
            prev_rptr = rptr;
        end
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    initial begin
        // Reset
        rrst = 1'b1; rq2_wptr = 5'd0;
        tick();
        chk_en = 1'b1;
        tick();
        chk("rst_rptr", rptr, 0);
        chk("rst_raddr", raddr, 0);
        chk("rst_rempty", rempty, 1);
        chk("rst_raempty", raempty, 1);
        chk("rst_rcount", rcount, 0);
        chk("rst_ruflow", ruflow, 0);

        // Fill and drain
        rrst = 1'b0; rq2_wptr = 5'b00010; ae_level = 5'd1;
        tick();
        chk("fill_rempty", rempty, 0);
        chk("fill_rcount", rcount, 3);
        chk("fill_raempty", raempty, 0);
        chk("model_cnt3", m_cnt, 3);
        rinc = 1'b1;
        tick(); tick();
        chk("drain2_rcount", rcount, 1);
        chk("drain2_raempty", raempty, 1);
        tick();
        chk("drain3_rempty", rempty, 1);
        chk("drain3_rcount", rcount, 0);
        chk("drain3_rptr", rptr, 5'b00010);
        chk("drain3_raddr", raddr, 3);
        rinc = 1'b0;

        // Underflow
        rinc = 1'b1;
        tick();
        rinc = 1'b0;
        chk("uf_rptr", rptr, 5'b00010);
        chk("uf_set", ruflow, 1);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("uf_sticky", ruflow, 1);
        end
        uflow_clr = 1'b1;
        tick();
        chk("uf_clr", ruflow, 0);
        rinc = 1'b1;
        tick();
        chk("uf_set_wins", ruflow, 1);
        chk("model_uf", m_uf, 1);
        rinc = 1'b0; uflow_clr = 1'b0;

        // Wrap: 32 pops with the writer kept up to 8 words ahead
        rrst = 1'b1; rq2_wptr = 5'd0;
        tick();
        rrst = 1'b0; rq2_wptr = 5'(gray(8));
        tick();
        for (int i = 0; i < 32; i++) begin
            rinc = 1'b1;
            rq2_wptr = 5'(gray(((i + 8 > 32) ? 32 : i + 8) % 32));
            tick();
            if (i == 30) chk("wrap_rptr31", rptr, 5'b10000);
            if (i == 31) chk("wrap_rptr0", rptr, 5'b00000);
`ifndef RPTR_LOOKAHEAD_EN
            if (i == 14) chk("wrap_raddr15", raddr, 15);
            if (i == 15) chk("wrap_raddr0", raddr, 0);
            if (i == 31) chk("wrap_raddr0b", raddr, 0);
`endif
        end
        chk("wrap_empty", rempty, 1);
        rinc = 1'b0;

        // Full count
        rrst = 1'b1; rq2_wptr = 5'd0;
        tick();
        rrst = 1'b0; rq2_wptr = 5'b11000; ae_level = 5'd4;
        tick();
        chk("full_rcount", rcount, 16);
        chk("full_raempty", raempty, 0);
        chk("full_rempty", rempty, 0);
        chk("model_cnt16", m_cnt, 16);
        rinc = 1'b1;
        repeat (12) tick();
        chk("pop12_rcount", rcount, 4);
        chk("pop12_raempty", raempty, 1);
        rinc = 1'b0;

        // Reset mid-pop
        rrst = 1'b1; rq2_wptr = 5'd0;
        tick();
        rrst = 1'b0; rq2_wptr = 5'b00111;
        tick();
        chk("mid_pre_rcount", rcount, 5);
        rinc = 1'b1; rrst = 1'b1;
        tick();
        rrst = 1'b0; rinc = 1'b0;
        chk("mid_rptr", rptr, 0);
        chk("mid_rcount", rcount, 0);
        chk("mid_rempty", rempty, 1);
        tick();
        chk("post_rempty", rempty, 0);
        chk("post_rcount", rcount, 5);
        chk("model_cnt5", m_cnt, 5);

        // Randomized traffic; writer never runs more than 16 words ahead
        wb = 5;
        for (int n = 0; n < 3000; n++) begin
            rrst = ($urandom_range(99) == 0);
            if (rrst) wb = 0;
            else if ($urandom_range(2) != 0 && ((wb - m_rbin) & 31) < 16) wb = (wb + 1) % 32;
            rq2_wptr  = 5'(gray(wb));
            rinc      = 1'($urandom_range(1));
            uflow_clr = ($urandom_range(7) == 0);
            if ($urandom_range(49) == 0) ae_level = 5'($urandom_range(31));
            tick();
        end

        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
